// File: rtl/instr_encoder_loader.sv
// Packs field-level RV32I requests into instruction words and
// writes each legal word to the next instruction-memory slot.
module instr_encoder_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       kind_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic             f7b5_i,
    input  logic [31:0]      imm_i,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic             full_o,
    output logic [CNT_W-1:0] word_count_o
);

    localparam logic [2:0] K_R    = 3'd0;
    localparam logic [2:0] K_I    = 3'd1;
    localparam logic [2:0] K_LUI  = 3'd2;
    localparam logic [2:0] K_SW   = 3'd3;
    localparam logic [2:0] K_LW   = 3'd4;
    localparam logic [2:0] K_JAL  = 3'd5;
    localparam logic [2:0] K_JALR = 3'd6;
    localparam logic [2:0] K_B    = 3'd7;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

    state_t      state;
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        f7b5;
    logic [31:0] imm;

    logic        is_shift;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [11:0] i_imm;
    logic [31:0] word;
    logic        bad_f3;
    logic        bad_rng;
    logic        bad_aln;
    logic        illegal;
    logic [1:0]  code;

    assign is_shift = (kind == K_I) && (f3 == 3'b001 || f3 == 3'b101);
    assign fits12   = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13   = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21   = (&imm[31:20]) | ~(|imm[31:20]);
    assign i_imm    = is_shift ? {1'b0, f7b5, 5'b0, imm[4:0]}
                               : imm[11:0];

    // Encode the captured request and grade its legality
    always_comb begin
        word    = '0;
        bad_f3  = 1'b0;
        bad_rng = 1'b0;
        bad_aln = 1'b0;
        unique case (kind)
            K_R: begin
                word = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            end
            K_I: begin
                word    = {i_imm, rs1, f3, rd, 7'b0010011};
                bad_f3  = (f3 == 3'b001) && f7b5;
                bad_rng = is_shift ? (|imm[31:5]) : !fits12;
            end
            K_LUI: begin
                word    = {imm[31:12], rd, 7'b0110111};
                bad_aln = |imm[11:0];
            end
            K_SW: begin
                word    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
                bad_rng = !fits12;
            end
            K_LW: begin
                word    = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
                bad_rng = !fits12;
            end
            K_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd,
                           7'b1101111};
                bad_rng = !fits21;
                bad_aln = imm[0];
            end
            K_JALR: begin
                word    = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                bad_rng = !fits12;
            end
            K_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1],
                           imm[11], 7'b1100011};
                bad_f3  = (f3 == 3'b010) || (f3 == 3'b011);
                bad_rng = !fits13;
                bad_aln = imm[0];
            end
        endcase
        illegal = bad_f3 | bad_rng | bad_aln;
        code    = bad_f3 ? 2'b11 : (bad_rng ? 2'b01 : 2'b10);
    end

    // Request FSM with registered handshake, write strobe and status
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_ready_o  <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            err_o        <= 1'b0;
            err_code_o   <= '0;
            full_o       <= 1'b0;
            word_count_o <= '0;
            kind         <= '0;
            f3           <= '0;
            rd           <= '0;
            rs1          <= '0;
            rs2          <= '0;
            f7b5         <= 1'b0;
            imm          <= '0;
        end else begin
            mem_we_o <= 1'b0;
            err_o    <= 1'b0;
            if (clear_i) begin
                state        <= IDLE;
                req_ready_o  <= 1'b0;
                full_o       <= 1'b0;
                word_count_o <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        req_ready_o <= 1'b1;
                        if (req_valid_i && req_ready_o) begin
                            kind        <= kind_i;
                            rd          <= rd_i;
                            rs1         <= rs1_i;
                            rs2         <= rs2_i;
                            f7b5        <= f7b5_i;
                            imm         <= imm_i;
                            f3          <= (kind_i == K_SW || kind_i == K_LW)
                                           ? 3'b010
                                           : (kind_i == K_JALR ? 3'b000
                                                               : funct3_i);
                            req_ready_o <= 1'b0;
                            state       <= ENC;
                        end
                    end
                    ENC: begin
                        if (illegal) begin
                            err_o       <= 1'b1;
                            err_code_o  <= code;
                            req_ready_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= BASE_ADDR
                                           + 32'({word_count_o, 2'b00});
                            mem_wdata_o <= word;
                            if (word_count_o != MAX_CNT)
                                word_count_o <= word_count_o + ONE;
                            state       <= WR;
                        end
                    end
                    WR: begin
                        if (word_count_o == MAX_CNT) begin
                            full_o <= 1'b1;
                            state  <= FULL;
                        end else begin
                            req_ready_o <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    FULL: begin
                        req_ready_o <= 1'b0;
                        full_o      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
